// File: rtl/lag_meter_pkg.sv
// Shared constants and state encoding for the lag meter.
// Defaults target a 74.25 MHz pixel clock with 1 us ticks.
package lag_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        TMO   = 2'd3
    } state_t;

    localparam int DEF_TICK_DIV      = 74;
    localparam int DEF_RESULT_WIDTH  = 24;
    localparam int DEF_TIMEOUT_TICKS = 500000;
    localparam int DEF_AVG_LOG2      = 3;

    localparam logic [DEF_RESULT_WIDTH-1:0] TIMEOUT_SENTINEL = '1;

endpackage

// File: rtl/lag_meter_sync_rise.sv
// Two-flop synchroniser for the photodiode level plus a
// history flop that yields a one-cycle rising-edge pulse.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= in;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~hist;

endmodule

// File: rtl/lag_meter.sv
// Times start-to-sensor-rise in prescaled ticks and publishes the
// last result plus a power-of-two running average as stable words.
module lag_meter
    import lag_meter_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int RESULT_WIDTH  = DEF_RESULT_WIDTH,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sensor,
    output logic                    busy,
    output logic [RESULT_WIDTH-1:0] lagLast,
    output logic [RESULT_WIDTH-1:0] lagAvg,
    output logic                    lastValid,
    output logic                    avgValid,
    output logic                    timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = RESULT_WIDTH + AVG_LOG2;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RESULT_WIDTH-1:0] CNT_LIMIT = RESULT_WIDTH'(TIMEOUT_TICKS);

    state_t                  state;
    logic [PW-1:0]           presc;
    logic [RESULT_WIDTH-1:0] cnt;
    logic [AW-1:0]           acc;
    logic [AVG_LOG2-1:0]     samples;

    logic sensor_level;
    logic sensor_rise;
    logic hit;
    logic tick;
    logic [AW-1:0] sum;

    sync_rise u_sync (
        .clk   (clk),
        .reset (reset),
        .in    (sensor),
        .level (sensor_level),
        .rise  (sensor_rise)
    );

    assign hit  = sensor_rise & sensor_level;
    assign tick = (presc == PRESC_LAST);
    assign sum  = acc + {{AVG_LOG2{1'b0}}, cnt};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            cnt       <= '0;
            acc       <= '0;
            samples   <= '0;
            busy      <= 1'b0;
            lagLast   <= '0;
            lagAvg    <= '0;
            lastValid <= 1'b0;
            avgValid  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            lastValid <= 1'b0;
            avgValid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    presc <= '0;
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                COUNT: begin
                    // Rise wins over tick/start/limit; cnt is frozen as the result.
                    if (hit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LIMIT) begin
                        state <= TMO;
                        busy  <= 1'b0;
                    end else if (start) begin
                        cnt   <= '0;
                        presc <= '0;
                    end else if (tick) begin
                        cnt   <= cnt + 1'b1;
                        presc <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    lagLast   <= cnt;
                    lastValid <= 1'b1;
                    timeout   <= 1'b0;
                    if (&samples) begin
                        lagAvg   <= sum[AVG_LOG2 +: RESULT_WIDTH];
                        avgValid <= 1'b1;
                        acc      <= '0;
                        samples  <= '0;
                    end else begin
                        acc     <= sum;
                        samples <= samples + 1'b1;
                    end
                end
                TMO: begin
                    state     <= IDLE;
                    lagLast   <= '1;
                    lastValid <= 1'b1;
                    timeout   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lag_meter.sv
// Directed bench for lag_meter with TICK_DIV=4, TIMEOUT_TICKS=100, AVG_LOG2=2.
module tb_lag_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sensor = 1'b0;
    logic        busy;
    logic [23:0] lagLast;
    logic [23:0] lagAvg;
    logic        lastValid;
    logic        avgValid;
    logic        timeout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lag_meter #(
        .TICK_DIV      (4),
        .RESULT_WIDTH  (24),
        .TIMEOUT_TICKS (100),
        .AVG_LOG2      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sensor    (sensor),
        .busy      (busy),
        .lagLast   (lagLast),
        .lagAvg    (lagAvg),
        .lastValid (lastValid),
        .avgValid  (avgValid),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start pulse sampled at the next edge; returns #1 after that edge.
    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Raise the pin so the FSM sees the rise while the count equals t.
    task automatic rise_after(input int t);
        cyc(4 * t - 1);
        sensor = 1'b1;
    endtask

    task automatic wait_done(output logic [23:0] last, output logic av);
        int n;
        n = 0;
        while (n < 1000 && !lastValid) begin
            cyc(1);
            n++;
        end
        check("done_seen", {31'd0, lastValid}, 32'd1);
        last = lagLast;
        av   = avgValid;
        cyc(1);
        check("pulse_len", {31'd0, lastValid}, 32'd0);
    endtask

    task automatic measure(input string tag, input int t, input logic exp_av);
        logic [23:0] last;
        logic av;
        do_start();
        rise_after(t);
        wait_done(last, av);
        check(tag, {8'd0, last}, t);
        check({tag, "_av"}, {31'd0, av}, {31'd0, exp_av});
        sensor = 1'b0;
        cyc(5);
    endtask

    initial begin
        logic [23:0] last;
        logic av;
        int pulses;

        cyc(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_last", {8'd0, lagLast}, 32'd0);
        check("rst_avg", {8'd0, lagAvg}, 32'd0);
        check("rst_lv", {31'd0, lastValid}, 32'd0);
        check("rst_av", {31'd0, avgValid}, 32'd0);
        check("rst_tmo", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        cyc(6);

        // basic
        do_start();
        check("busy_on", {31'd0, busy}, 32'd1);
        rise_after(37);
        wait_done(last, av);
        check("basic_last", {8'd0, last}, 32'd37);
        check("basic_busy", {31'd0, busy}, 32'd0);
        check("basic_tmo", {31'd0, timeout}, 32'd0);
        check("basic_avg", {8'd0, lagAvg}, 32'd0);
        sensor = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);

        // average of 10,20,30,41 -> 101>>2 = 25
        measure("avg1", 10, 1'b0);
        measure("avg2", 20, 1'b0);
        measure("avg3", 30, 1'b0);
        measure("avg4", 41, 1'b1);
        check("avg_val", {8'd0, lagAvg}, 32'd25);
        measure("avg5", 7, 1'b0);
        check("avg_hold", {8'd0, lagAvg}, 32'd25);

        // timeout
        do_start();
        wait_done(last, av);
        check("tmo_last", {8'd0, last}, 32'h00ffffff);
        check("tmo_flag", {31'd0, timeout}, 32'd1);
        check("tmo_avg", {8'd0, lagAvg}, 32'd25);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        cyc(3);
        measure("post_tmo", 12, 1'b0);
        check("tmo_clear", {31'd0, timeout}, 32'd0);
        // samples so far 7,12 -> two more complete the set: 48>>2 = 12
        measure("cnt_a", 13, 1'b0);
        measure("cnt_b", 16, 1'b1);
        check("avg2_val", {8'd0, lagAvg}, 32'd12);

        // restart at tick 5
        do_start();
        cyc(20);
        do_start();
        rise_after(20);
        wait_done(last, av);
        check("restart", {8'd0, last}, 32'd20);
        sensor = 1'b0;
        cyc(5);

        // start collides with rise
        do_start();
        rise_after(8);
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done(last, av);
        check("coll_last", {8'd0, last}, 32'd8);
        check("coll_busy", {31'd0, busy}, 32'd0);
        cyc(3);
        check("coll_idle", {31'd0, busy}, 32'd0);
        sensor = 1'b0;
        cyc(5);

        // sensor held high through start
        sensor = 1'b1;
        cyc(5);
        do_start();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (lastValid) pulses++;
        end
        check("held_none", pulses, 32'd0);
        check("held_busy", {31'd0, busy}, 32'd1);
        sensor = 1'b0;
        cyc(4 * 15 - 1 - 20);
        sensor = 1'b1;
        wait_done(last, av);
        check("held_last", {8'd0, last}, 32'd15);
        sensor = 1'b0;
        cyc(5);

        // reset mid-measurement after three averaged samples (20,8,15)
        do_start();
        cyc(200);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        cyc(1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_last", {8'd0, lagLast}, 32'd0);
        check("mr_avg", {8'd0, lagAvg}, 32'd0);
        check("mr_tmo", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        cyc(5);
        measure("new1", 4, 1'b0);
        measure("new2", 8, 1'b0);
        measure("new3", 12, 1'b0);
        measure("new4", 17, 1'b1);
        check("new_avg", {8'd0, lagAvg}, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lag_meter.md
Name: lag_meter

Overview:
Source-domain measurement engine for the lag tester. It times the interval from a "flash emitted" start pulse to the photodiode sensor's rising edge, in microsecond ticks. It publishes the last result and an N-sample average as stable 24-bit words. The words change only on completion, so the downstream change-triggered clock-domain crossing writes exactly once per update.

Parameters:
TICK_DIV, 74, clk cycles per measurement tick (1 us at 74.25 MHz pixel clock), must be >= 2
RESULT_WIDTH, 24, width of lag results in ticks
TIMEOUT_TICKS, 500000, ticks after start before a measurement is abandoned, must be < 2^RESULT_WIDTH - 1
AVG_LOG2, 3, log2 of samples per average (8)

Ports:
clk  input  1  single clock; all logic is posedge clk
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse, flash frame emitted
sensor  input  1  raw asynchronous photodiode comparator level
busy  output  1  high while a measurement is in progress (COUNT state)
lagLast  output  RESULT_WIDTH  last result in ticks; all-ones after a timeout
lagAvg  output  RESULT_WIDTH  mean of the last 2^AVG_LOG2 valid results
lastValid  output  1  one-cycle pulse when lagLast updates
avgValid  output  1  one-cycle pulse when lagAvg updates
timeout  output  1  sticky; set on timeout, cleared by the next valid completion

Behaviour:
- Reset: state IDLE; busy, lastValid, avgValid and timeout 0; lagLast and lagAvg 0; prescaler, tick count, accumulator and sample count 0; synchroniser flops 0.
- Sensor path: 2-flop synchroniser plus one history flop. sensorRise = sync & ~hist. Pin-to-rise latency is 2-3 clk.
- Prescaler: counts 0..TICK_DIV-1. tick is high when prescaler == TICK_DIV-1. It is forced to 0 on an accepted start, so the first tick comes TICK_DIV cycles after start.
- FSM states: IDLE, COUNT, DONE, TMO.
- IDLE: on start, go to COUNT; clear tick count and prescaler.
- COUNT: busy = 1.
  - On tick, tick count increments.
  - If sensorRise, go to DONE. This has priority over tick, start and timeout in the same cycle. The count captured is the value before that cycle's increment.
  - Else if the count reaches TIMEOUT_TICKS, go to TMO.
  - Else if start, restart: clear count and prescaler, stay in COUNT.
- DONE (1 cycle):
  - lagLast <= captured count; lastValid = 1; timeout <= 0.
  - acc <= acc + count; sampleCnt++.
  - If sampleCnt was 2^AVG_LOG2-1: lagAvg <= (acc+count) >> AVG_LOG2 (truncating); avgValid = 1; acc and sampleCnt cleared.
  - Next state IDLE.
- TMO (1 cycle): lagLast <= all ones; lastValid = 1; timeout <= 1. The accumulator is untouched (timeouts are excluded from the average). Next state IDLE.
- A start in DONE or TMO is dropped.
- Widths: acc is RESULT_WIDTH+AVG_LOG2 bits and cannot overflow. The tick count cannot exceed TIMEOUT_TICKS.
- Outputs are registered and hold between updates. lagLast and lagAvg never glitch or change except in DONE/TMO.
- Sensor already high at start: no rise occurs, so the measurement waits for the sensor to go low and rise again, or times out.
- Reset mid-measurement: immediate return to IDLE and all reset values. Partial average is discarded.

Decomposition:
- Package lag_meter_pkg:
  - FSM state encoding (IDLE=0, COUNT=1, DONE=2, TMO=3).
  - Default TICK_DIV, TIMEOUT_TICKS and AVG_LOG2 constants.
  - Timeout sentinel constant (all ones).
- Sub-module sync_rise: 2-flop synchroniser plus rising-edge detector, parameterless, with ports clk, reset, in, level, rise.
- Prescaler, FSM and averager stay in lag_meter.

Test Plan:
Bench parameters throughout: TICK_DIV=4, TIMEOUT_TICKS=100, AVG_LOG2=2.
- Basic: start at cycle 10; sensor rises at cycle 10+4*37+1. Expect lagLast=37, one lastValid pulse, busy low afterwards, timeout=0, lagAvg still 0.
- Average: four measurements of 10, 20, 30, 41 ticks. Expect avgValid only after the 4th, lagAvg=25 (101>>2 truncated); a 5th sample leaves lagAvg unchanged.
- Timeout: start with no sensor rise. After 100 ticks, lagLast=0xFFFFFF, timeout=1, lagAvg and the sample count are unchanged. A following valid 12-tick measurement gives lagLast=12 and timeout=0.
- Restart/collision:
  - A start at tick 5 of COUNT restarts; a rise 20 ticks later gives lagLast=20.
  - Start and rise in the same COUNT cycle: the completion is reported and the start is dropped (busy=0 next-but-one cycle).
- Sensor held high through start: no completion until the sensor drops and rises again. A re-rise at tick 15 gives lagLast=15.
- Reset at tick 50 of COUNT, after 3 averaged samples. All outputs return to 0 and state to IDLE. A new 4-sample run averages only the new samples.
